bus4_nibble_receiver: RTL and testbench

BUS4_NIBBLE_RECEIVER -- requirements
Module: bus4_nibble_receiver

---
 rtl/bus4_nibble_receiver.sv | 164 ++++++++++++++++
 tb/tb_bus4_nibble_receiver.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bus4_nibble_receiver.sv
// bus4_nibble_receiver: assembles 16-bit words from a 4-bit nibble bus and
// queues them in a first-word-fall-through buffer.
// Optional macro PARITY_CHECK_EN: drop words containing a nibble with bad
// even parity and pulse parity_err.
module bus4_nibble_receiver #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  bus_data,
  input  logic        bus_valid,
  input  logic        bus_first,
  input  logic        bus_par,
  output logic        bus_ready,
  output logic [15:0] word_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        framing_err,
  output logic        parity_err
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {IDLE = 1'b0, ASSEMBLE = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [11:0]        asm_q, asm_d;
  logic               bad_q, bad_d;
  logic               framing_err_q, framing_err_d;
  logic               parity_err_q, parity_err_d;
  logic [15:0]        mem_q [FIFO_DEPTH];
  logic [15:0]        mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               nib_xfer_c;
  logic               nib_bad_c;
  logic               push_c;
  logic               pop_c;
  logic [15:0]        push_word_c;

`ifdef PARITY_CHECK_EN
  assign nib_bad_c  = ^{bus_data, bus_par};
  assign parity_err = parity_err_q;
`else
  logic unused_par_c;
  assign nib_bad_c    = 1'b0;
  assign parity_err   = 1'b0;
  assign unused_par_c = ^{bus_par, parity_err_q};
`endif

  assign bus_ready   = (count_q != CNT_W'(FIFO_DEPTH));
  assign word_valid  = (count_q != '0);
  assign word_data   = mem_q[rd_ptr_q];
  assign framing_err = framing_err_q;
  assign nib_xfer_c  = bus_valid & bus_ready;
  assign pop_c       = word_valid & word_ready;
  assign push_word_c = {asm_q, bus_data};

  // Word assembly FSM: tracks nibble position, framing and parity marks.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    asm_d         = asm_q;
    bad_d         = bad_q;
    framing_err_d = 1'b0;
    parity_err_d  = 1'b0;
    push_c        = 1'b0;
    if (nib_xfer_c) begin
      unique case (state_q)
        IDLE: begin
          if (bus_first) begin
            asm_d   = {bus_data, 8'h00};
            idx_d   = 2'd1;
            bad_d   = nib_bad_c;
            state_d = ASSEMBLE;
          end else begin
            framing_err_d = 1'b1;
          end
        end
        ASSEMBLE: begin
          if (bus_first) begin
            // Restart: the partial word and its parity mark are abandoned.
            framing_err_d = 1'b1;
            asm_d         = {bus_data, 8'h00};
            idx_d         = 2'd1;
            bad_d         = nib_bad_c;
          end else if (idx_q == 2'd3) begin
            if (bad_q | nib_bad_c) begin
              parity_err_d = 1'b1;
            end else begin
              push_c = 1'b1;
            end
            idx_d   = 2'd0;
            bad_d   = 1'b0;
            state_d = IDLE;
          end else begin
            if (idx_q == 2'd1) begin
              asm_d[7:4] = bus_data;
            end else begin
              asm_d[3:0] = bus_data;
            end
            idx_d = idx_q + 2'd1;
            bad_d = bad_q | nib_bad_c;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FWFT buffer: push from the assembler, pop on a consumer beat.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) begin
      mem_d[wr_ptr_q] = push_word_c;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push_c, pop_c})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= 2'd0;
      asm_q         <= '0;
      bad_q         <= 1'b0;
      framing_err_q <= 1'b0;
      parity_err_q  <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      asm_q         <= asm_d;
      bad_q         <= bad_d;
      framing_err_q <= framing_err_d;
      parity_err_q  <= parity_err_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      mem_q         <= mem_d;
    end
  end

endmodule

// File: tb/tb_bus4_nibble_receiver.sv
// Directed bench for bus4_nibble_receiver (FIFO_DEPTH = 4).
module tb_bus4_nibble_receiver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  bus_data;
  logic        bus_valid;
  logic        bus_first;
  logic        bus_par;
  logic        bus_ready;
  logic [15:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic        framing_err;
  logic        parity_err;

  int checks = 0;
  int passed = 0;

  bus4_nibble_receiver #(.FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus_data    (bus_data),
    .bus_valid   (bus_valid),
    .bus_first   (bus_first),
    .bus_par     (bus_par),
    .bus_ready   (bus_ready),
    .word_data   (word_data),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .framing_err (framing_err),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one nibble, wait (bounded) for acceptance, then deassert valid.
  task automatic send_nib(input logic [3:0] d, input logic first, input logic par_bad);
    int waits;
    waits     = 0;
    bus_data  = d;
    bus_first = first;
    bus_par   = (^d) ^ par_bad;
    bus_valid = 1'b1;
    while (!bus_ready && waits < 50) begin
      tick();
      waits++;
    end
    if (!bus_ready) begin
      checks++;
      $error("FAIL ready_timeout observed=0 expected=1");
    end
    tick();
    bus_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    logic [15:0] t;
    t = w;
    send_nib(t[15:12], 1'b1, 1'b0);
    send_nib(t[11:8],  1'b0, 1'b0);
    send_nib(t[7:4],   1'b0, 1'b0);
    send_nib(t[3:0],   1'b0, 1'b0);
  endtask

  initial begin
    rst_n      = 1'b0;
    bus_data   = 4'h0;
    bus_valid  = 1'b0;
    bus_first  = 1'b0;
    bus_par    = 1'b0;
    word_ready = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_word_valid", 16'(word_valid), 16'h0);
    chk("rst_framing_err", 16'(framing_err), 16'h0);
    chk("rst_parity_err", 16'(parity_err), 16'h0);
    chk("rst_word_data", word_data, 16'h0000);
    chk("rst_bus_ready", 16'(bus_ready), 16'h1);
    rst_n = 1'b1;
    tick();

    // Basic word ABCD, valid for exactly one cycle after D
    word_ready = 1'b1;
    send_nib(4'hA, 1'b1, 1'b0);
    send_nib(4'hB, 1'b0, 1'b0);
    send_nib(4'hC, 1'b0, 1'b0);
    chk("basic_not_yet_valid", 16'(word_valid), 16'h0);
    send_nib(4'hD, 1'b0, 1'b0);
    chk("basic_valid", 16'(word_valid), 16'h1);
    chk("basic_data", word_data, 16'hABCD);
    tick();
    chk("basic_valid_one_cycle", 16'(word_valid), 16'h0);

    // Stray non-first nibble in IDLE
    send_nib(4'h5, 1'b0, 1'b0);
    chk("stray_framing_pulse", 16'(framing_err), 16'h1);
    chk("stray_no_word", 16'(word_valid), 16'h0);
    tick();
    chk("stray_framing_clear", 16'(framing_err), 16'h0);
    chk("stray_still_no_word", 16'(word_valid), 16'h0);

    // Framing restart: 1,2 then 7(first),8,9,A -> 789A only
    send_nib(4'h1, 1'b1, 1'b0);
    chk("frame_n0_no_err", 16'(framing_err), 16'h0);
    send_nib(4'h2, 1'b0, 1'b0);
    send_nib(4'h7, 1'b1, 1'b0);
    chk("frame_restart_pulse", 16'(framing_err), 16'h1);
    send_nib(4'h8, 1'b0, 1'b0);
    chk("frame_pulse_once", 16'(framing_err), 16'h0);
    send_nib(4'h9, 1'b0, 1'b0);
    chk("frame_no_word_yet", 16'(word_valid), 16'h0);
    send_nib(4'hA, 1'b0, 1'b0);
    chk("frame_valid", 16'(word_valid), 16'h1);
    chk("frame_data", word_data, 16'h789A);
    chk("frame_no_err_end", 16'(framing_err), 16'h0);
    tick();
    chk("frame_single_word", 16'(word_valid), 16'h0);

    // Backpressure: fill 4 entries, stall 5th, then drain in order
    word_ready = 1'b0;
    send_word(16'h1111);
    chk("bp_occ1_ready", 16'(bus_ready), 16'h1);
    send_word(16'h2222);
    send_word(16'h3333);
    send_word(16'h4444);
    chk("bp_full_not_ready", 16'(bus_ready), 16'h0);
    chk("bp_head", word_data, 16'h1111);
    bus_data  = 4'h5;
    bus_first = 1'b1;
    bus_par   = 1'b0;
    bus_valid = 1'b1;
    tick();
    tick();
    chk("bp_stall_ready", 16'(bus_ready), 16'h0);
    chk("bp_head_stable", word_data, 16'h1111);
    chk("bp_valid_held", 16'(word_valid), 16'h1);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    chk("bp_pop1_ready", 16'(bus_ready), 16'h1);
    chk("bp_head2", word_data, 16'h2222);
    send_word(16'h5555);
    chk("bp_full_again", 16'(bus_ready), 16'h0);
    word_ready = 1'b1;
    chk("bp_out2", word_data, 16'h2222);
    tick();
    chk("bp_out3", word_data, 16'h3333);
    tick();
    chk("bp_out4", word_data, 16'h4444);
    tick();
    chk("bp_out5", word_data, 16'h5555);
    chk("bp_out5_valid", 16'(word_valid), 16'h1);
    tick();
    chk("bp_drained", 16'(word_valid), 16'h0);
    chk("bp_drained_ready", 16'(bus_ready), 16'h1);

    // Reset mid-word discards the partial word
    send_nib(4'h1, 1'b1, 1'b0);
    send_nib(4'h2, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_word_valid", 16'(word_valid), 16'h0);
    chk("midrst_bus_ready", 16'(bus_ready), 16'h1);
    tick();
    rst_n = 1'b1;
    tick();
    send_nib(4'h3, 1'b0, 1'b0);
    chk("midrst_needs_first", 16'(framing_err), 16'h1);
    send_nib(4'h4, 1'b0, 1'b0);
    chk("midrst_no_stale_word", 16'(word_valid), 16'h0);
    send_word(16'hBEEF);
    chk("midrst_valid", 16'(word_valid), 16'h1);
    chk("midrst_data", word_data, 16'hBEEF);
    tick();
    chk("midrst_only_one", 16'(word_valid), 16'h0);

    // Parity error on the last nibble of 1234
    send_nib(4'h1, 1'b1, 1'b0);
    send_nib(4'h2, 1'b0, 1'b0);
    send_nib(4'h3, 1'b0, 1'b0);
    send_nib(4'h4, 1'b0, 1'b1);
`ifdef PARITY_CHECK_EN
    chk("par_err_pulse", 16'(parity_err), 16'h1);
    chk("par_word_dropped", 16'(word_valid), 16'h0);
    tick();
    chk("par_err_once", 16'(parity_err), 16'h0);
    chk("par_still_no_word", 16'(word_valid), 16'h0);
`else
    chk("par_ignored_err", 16'(parity_err), 16'h0);
    chk("par_ignored_valid", 16'(word_valid), 16'h1);
    chk("par_ignored_data", word_data, 16'h1234);
    tick();
    chk("par_ignored_popped", 16'(word_valid), 16'h0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
